// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: one bit per clock, MSB first, over WIDTH cycles.
// Produces a registered one-hot gt/eq/ls result with a single-cycle done pulse.
module serial_comparator #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_ls_b
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] sa, sb;
   logic [CNT_W-1:0] cnt;
   logic             dec;
   logic             gt_f, ls_f;

   logic             load, last;
   logic             differ;
   logic             gt_nxt, ls_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The first differing bit pair (from the MSB) decides; once decided, flags are frozen.
   assign differ = ~dec & (sa[WIDTH-1] ^ sb[WIDTH-1]);
   assign gt_nxt = differ ? sa[WIDTH-1] : gt_f;
   assign ls_nxt = differ ? sb[WIDTH-1] : ls_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         cnt    <= '0;
         dec    <= 1'b0;
         gt_f   <= 1'b0;
         ls_f   <= 1'b0;
         done   <= 1'b0;
         a_gt_b <= 1'b0;
         a_eq_b <= 1'b0;
         a_ls_b <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            sa   <= a;
            sb   <= b;
            cnt  <= CNT_W'(WIDTH - 1);
            dec  <= 1'b0;
            gt_f <= 1'b0;
            ls_f <= 1'b0;
         end else if (state == SHIFT) begin
            sa   <= {sa[WIDTH-2:0], 1'b0};
            sb   <= {sb[WIDTH-2:0], 1'b0};
            cnt  <= cnt - CNT_W'(1);
            dec  <= dec | differ;
            gt_f <= gt_nxt;
            ls_f <= ls_nxt;
            // Last bit's contribution is folded in via gt_nxt/ls_nxt.
            if (last) begin
               a_gt_b <= gt_nxt;
               a_ls_b <= ls_nxt;
               a_eq_b <= ~(gt_nxt | ls_nxt);
               done   <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator: directed scenarios plus random pairs
// checked against an arithmetic reference comparison.
module tb_serial_comparator;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, a_gt_b, a_eq_b, a_ls_b;

   int pass_cnt = 0;
   int total    = 0;

   serial_comparator #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .a_gt_b(a_gt_b),
      .a_eq_b(a_eq_b),
      .a_ls_b(a_ls_b)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: plain unsigned arithmetic, packed as {gt, eq, ls}.
   function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
      int ux, uy;
      ux = int'(x);
      uy = int'(y);
      return {ux > uy, ux == uy, ux < uy};
   endfunction

   function automatic logic [2:0] res();
      return {a_gt_b, a_eq_b, a_ls_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one start pulse and wait (bounded) for done; lat=-1 on timeout.
   task automatic run_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              output int lat, output bit busy_ok);
      a = ta; b = tb_; start = 1'b1;
      tick();
      start   = 1'b0;
      busy_ok = busy;
      lat     = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (done) begin
            lat = i;
            if (busy) busy_ok = 1'b0;
            break;
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if ({busy, done, a_gt_b, a_eq_b, a_ls_b} !== 5'b0) begin
         $display("FAIL reset_outputs: got %b required 00000", {busy, done, a_gt_b, a_eq_b, a_ls_b});
      end else pass_cnt++;
   endtask

   task automatic test_directed();
      logic [W-1:0] da [5] = '{4'b0101, 4'b0001, 4'b1100, 4'b1111, 4'b0000};
      logic [W-1:0] db [5] = '{4'b0101, 4'b0000, 4'b1101, 4'b0001, 4'b0001};
      int lat;
      bit bok;
      for (int i = 0; i < 5; i++) begin
         run_compare(da[i], db[i], lat, bok);
         total++;
         if (lat !== W) $display("FAIL dir_latency[%0d]: got %0d required %0d", i, lat, W);
         else pass_cnt++;
         total++;
         if (!bok) $display("FAIL dir_busy[%0d]: got busy profile wrong required high until done", i);
         else pass_cnt++;
         total++;
         if (res() !== ref_cmp(da[i], db[i]))
            $display("FAIL dir_result[%0d] %b vs %b: got %b required %b", i, da[i], db[i], res(), ref_cmp(da[i], db[i]));
         else pass_cnt++;
         tick();
         total++;
         if (done !== 1'b0) $display("FAIL dir_done_pulse[%0d]: got %b required 0", i, done);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      int ndone = 0;
      a = 4'b0010; b = 4'b0011; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 4'b1000; b = 4'b0000; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 3; i <= 12; i++) begin
         tick();
         if (done) begin lat = i; break; end
      end
      total++;
      if (lat !== W) $display("FAIL ign_latency: got %0d required %0d", lat, W);
      else pass_cnt++;
      total++;
      if (res() !== 3'b001) $display("FAIL ign_result: got %b required 001", res());
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done || busy) ndone++;
         total++;
         if (res() !== 3'b001) $display("FAIL ign_hold[%0d]: got %b required 001", i, res());
         else pass_cnt++;
      end
      total++;
      if (ndone !== 0) $display("FAIL ign_no_second: got %0d busy/done cycles required 0", ndone);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      int lat;
      bit bok;
      a = 4'b0111; b = 4'b0110; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      total++;
      if ({busy, done, a_gt_b, a_eq_b, a_ls_b} !== 5'b0)
         $display("FAIL abort_outputs: got %b required 00000", {busy, done, a_gt_b, a_eq_b, a_ls_b});
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) ndone++;
      end
      total++;
      if (ndone !== 0) $display("FAIL abort_no_done: got %0d busy/done cycles required 0", ndone);
      else pass_cnt++;
      run_compare(4'b1000, 4'b1000, lat, bok);
      total++;
      if (lat !== W || res() !== 3'b010)
         $display("FAIL abort_recover: got lat %0d res %b required lat %0d res 010", lat, res(), W);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pa [9] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h7, 4'h8, 4'hC, 4'hF, 4'h0};
      logic [W-1:0] pb [9] = '{4'h0, 4'h0, 4'h3, 4'h5, 4'h6, 4'h8, 4'hD, 4'h1, 4'hF};
      int lat;
      tick();
      a = pa[0]; b = pb[0]; start = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin a = pa[i+1]; b = pb[i+1]; end
         else start = 1'b0;
         lat = -1;
         for (int j = 1; j <= 10; j++) begin
            tick();
            if (done) begin lat = j; break; end
         end
         total++;
         if (lat !== W) $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, W);
         else pass_cnt++;
         total++;
         if (res() !== ref_cmp(pa[i], pb[i]))
            $display("FAIL b2b_result[%0d]: got %b required %b", i, res(), ref_cmp(pa[i], pb[i]));
         else pass_cnt++;
         if (i < 8) begin
            tick();
            total++;
            if (busy !== 1'b1) $display("FAIL b2b_restart[%0d]: got busy %b required 1", i, busy);
            else pass_cnt++;
         end
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      int lat;
      bit bok;
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = (i % 4 == 0) ? ra : W'($urandom);
         run_compare(ra, rb, lat, bok);
         total++;
         if (lat !== W || !bok || res() !== ref_cmp(ra, rb))
            $display("FAIL rand[%0d] %b vs %b: got lat %0d busy_ok %0d res %b required lat %0d busy_ok 1 res %b",
                     i, ra, rb, lat, bok, res(), W, ref_cmp(ra, rb));
         else pass_cnt++;
         if ($urandom_range(1, 0) == 1) tick();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
